// File: rtl/riscv_pkg.sv
// Shared constants for the memory stage: load/store width codes and FSM encoding.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  // Stores only know B/H/W, so BU/HU (and any unknown code) on a store count as W.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off,
                                         input logic store);
    logic m;
    case (f3)
      F3_B:    m = 1'b0;
      F3_H:    m = off[0];
      F3_BU:   m = store ? (off != 2'b00) : 1'b0;
      F3_HU:   m = store ? (off != 2'b00) : off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Ready-handshaked data memory bus between the memory stage and the data memory.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ready, rdata);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/load_store_align.sv
// Store lane replication / byte enables and load byte-half select with extension.
module load_store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata = st_data;
    st_be    = 4'b1111;
    case (st_funct3)
      F3_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << st_off;
      end
      F3_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: issues loads/stores on the data bus, stalls while waiting,
// and registers formatted results into MEM/WB.
module mem_access_stage #(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_RegWrite,
  input  logic        mem_MemtoReg,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [2:0]  mem_funct3,
  input  logic [4:0]  mem_rd,
  mem_access_stage_if.master dmem,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        bus_error_out,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_rd
);
  import riscv_pkg::*;

  localparam logic       TIMEOUT_EN  = (WAIT_TIMEOUT != 0);
  localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_TIMEOUT);

  mem_state_t  state;
  logic [7:0]  wait_cnt;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_alu;
  logic [4:0]  lat_rd;
  logic        lat_regwrite;
  logic        lat_memtoreg;
  logic        lat_read;

  logic        access;
  logic        misal;
  logic        timeout;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  assign access  = mem_valid & (mem_MemRead | mem_MemWrite);
  assign misal   = access & is_misaligned(mem_funct3, mem_alu_result[1:0], mem_MemWrite);
  assign timeout = TIMEOUT_EN && (wait_cnt == TIMEOUT_CNT);

  load_store_align u_align (
    .st_funct3 (mem_funct3),
    .st_off    (mem_alu_result[1:0]),
    .st_data   (mem_write_data),
    .ld_funct3 (lat_funct3),
    .ld_off    (lat_alu[1:0]),
    .rdata     (dmem.rdata),
    .st_wdata  (st_wdata),
    .st_be     (st_be),
    .ld_data   (ld_data)
  );

  // Gated by rst so the stall drops the instant reset is asserted.
  always_comb begin
    stall_out = 1'b0;
    case (state)
      ST_IDLE:   stall_out = access & ~misal;
      ST_ACCESS: stall_out = ~dmem.ready & ~timeout;
      default:   stall_out = 1'b0;
    endcase
    stall_out = stall_out & ~rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= 8'd0;
      lat_funct3    <= 3'd0;
      lat_alu       <= 32'd0;
      lat_rd        <= 5'd0;
      lat_regwrite  <= 1'b0;
      lat_memtoreg  <= 1'b0;
      lat_read      <= 1'b0;
      dmem.req      <= 1'b0;
      dmem.we       <= 1'b0;
      dmem.addr     <= 32'd0;
      dmem.wdata    <= 32'd0;
      dmem.be       <= 4'd0;
      misalign_out  <= 1'b0;
      bus_error_out <= 1'b0;
      wb_valid      <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_MemtoReg   <= 1'b0;
      wb_read_data  <= 32'd0;
      wb_alu_result <= 32'd0;
      wb_rd         <= 5'd0;
    end else begin
      misalign_out  <= 1'b0;
      bus_error_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access && !misal) begin
            state        <= ST_ACCESS;
            wait_cnt     <= 8'd0;
            dmem.req     <= 1'b1;
            dmem.we      <= mem_MemWrite;
            dmem.addr    <= {mem_alu_result[31:2], 2'b00};
            dmem.wdata   <= st_wdata;
            dmem.be      <= mem_MemWrite ? st_be : 4'b1111;
            lat_funct3   <= mem_funct3;
            lat_alu      <= mem_alu_result;
            lat_rd       <= mem_rd;
            lat_regwrite <= mem_RegWrite;
            lat_memtoreg <= mem_MemtoReg;
            lat_read     <= mem_MemRead & ~mem_MemWrite;
            // Bubble into MEM/WB while the access is outstanding.
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
          end else begin
            wb_valid      <= mem_valid & ~misal;
            wb_RegWrite   <= mem_RegWrite & ~misal;
            wb_MemtoReg   <= mem_MemtoReg;
            wb_read_data  <= 32'd0;
            wb_alu_result <= mem_alu_result;
            wb_rd         <= mem_rd;
            misalign_out  <= misal;
          end
        end
        ST_ACCESS: begin
          if (dmem.ready) begin
            state         <= ST_IDLE;
            dmem.req      <= 1'b0;
            wb_valid      <= 1'b1;
            wb_RegWrite   <= lat_regwrite;
            wb_MemtoReg   <= lat_memtoreg;
            wb_read_data  <= lat_read ? ld_data : 32'd0;
            wb_alu_result <= lat_alu;
            wb_rd         <= lat_rd;
          end else if (timeout) begin
            state         <= ST_IDLE;
            dmem.req      <= 1'b0;
            bus_error_out <= 1'b1;
            wb_valid      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_MemtoReg   <= lat_memtoreg;
            wb_read_data  <= 32'd0;
            wb_alu_result <= lat_alu;
            wb_rd         <= lat_rd;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage RISC-V pipeline. It takes the EX/MEM register contents (ALU result as address, forwarded store data, control bits), runs loads and stores on a ready-handshaked data bus, and formats load data with byte-lane select and sign/zero extension. It drives the stall to the hazard unit and registers results into MEM/WB, where they feed write-back and the `wb_alu_result` forwarding path.

## Interface
Parameters:
- `WAIT_TIMEOUT`, default 255: max cycles in ACCESS without `dmem_ready`; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_valid` in 1: EX/MEM holds a live instruction.
- `mem_RegWrite`, `mem_MemtoReg`, `mem_MemRead`, `mem_MemWrite` in 1 each: control from EX/MEM.
- `mem_alu_result` in 32: byte address, or non-memory result.
- `mem_write_data` in 32: store data (rs2, already forwarded).
- `mem_funct3` in 3: access width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `mem_rd` in 5: destination register.
- `dmem_req` out 1: bus request, registered.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_be` out 4: byte enables.
- `dmem_ready` in 1: bus completes this cycle; `dmem_rdata` is valid.
- `dmem_rdata` in 32: read word.
- `stall_out` out 1: freeze PC, IF/ID, ID/EX, EX/MEM.
- `misalign_out` out 1: one-cycle pulse, misaligned access squashed.
- `bus_error_out` out 1: one-cycle pulse, access timed out.
- `wb_valid`, `wb_RegWrite`, `wb_MemtoReg` out 1 each: MEM/WB control.
- `wb_read_data` out 32: formatted load data.
- `wb_alu_result` out 32: passthrough ALU result.
- `wb_rd` out 5: destination register.

## Operation
- FSM states are IDLE and ACCESS.
- "Access" means `mem_valid & (mem_MemRead | mem_MemWrite)`.
- IDLE, non-access: MEM/WB loads the inputs each cycle (`wb_valid=mem_valid`). No stall.
- IDLE, aligned access: register the `dmem_*` outputs, `dmem_req=1`, go to ACCESS. `stall_out=1` combinationally this cycle.
- Misaligned access (H with addr[0]=1; W with addr[1:0]≠0): no bus request. MEM/WB loads with `wb_valid=0` and `wb_RegWrite=0`. `misalign_out` pulses the next cycle. No stall.
- ACCESS, `dmem_ready=0`: hold all `dmem_*` outputs stable; `stall_out=1`; wait counter increments.
- ACCESS, `dmem_ready=1`: `stall_out=0`, so EX/MEM advances. MEM/WB loads formatted `dmem_rdata` (loads) and the control bits. `dmem_req` drops next cycle; return to IDLE.
- ACCESS, counter reaches `WAIT_TIMEOUT` with `dmem_ready=0`: drop `dmem_req`, squash into MEM/WB (`wb_valid=0`), pulse `bus_error_out`, return to IDLE. If ready and timeout coincide, ready wins.
- Store formatting:
  - SB: wdata `{4{d[7:0]}}`, be `4'b0001<<addr[1:0]`.
  - SH: wdata `{2{d[15:0]}}`, be `0011` (addr[1]=0) or `1100`.
  - SW: wdata = d, be `1111`.
  - Loads: be `1111`, `we=0`.
- Load formatting: select byte by addr[1:0] or half by addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Unknown `mem_funct3` on an access is treated as W.
- `dmem_ready` in IDLE is ignored.

## Timing
- Reset (async, immediate): state IDLE, counter 0, and every output 0 (`dmem_*`, `stall_out`, `misalign_out`, `bus_error_out`, all `wb_*`). Reset mid-access drops `dmem_req` at once; there is no retry.
- Non-memory instruction: 1 cycle in MEM, 0 stall cycles.
- Memory access with ready at first sample: 2 cycles in MEM, 1 stall cycle. Each extra wait cycle adds one stall cycle.
- `dmem_req` is high for exactly the ACCESS cycles. Address, data, be and we stay constant while req is high.
- `stall_out` is combinational from state, inputs and `dmem_ready`. All other outputs are registered.
- Back-to-back accesses: IDLE is re-entered for the cycle after completion, so `dmem_req` is low for at least 1 cycle between accesses.
- Wait counter is 8 bits wide (saturating) and clears on entering ACCESS.

## Structure
- Shared `riscv_pkg` holds:
  - funct3 load/store width constants;
  - state encoding (IDLE=0, ACCESS=1).
- Combinational sub-module `load_store_align`:
  - store lane replication and byte enables;
  - load byte/half select and extension.
- The FSM, counter and MEM/WB register stay in `mem_access_stage`.

## Test plan
- ADD passthrough (`mem_alu_result=0x1234`, no access) -> next cycle `wb_alu_result=0x1234`, `wb_valid=1`; `stall_out` never high.
- LB from addr 0x103 with rdata 0x80FF_FF_FF, ready on first ACCESS cycle -> `dmem_addr=0x100`, stall 1 cycle, `wb_read_data=0xFFFFFF80`. Repeat with LBU -> 0x00000080.
- SH data 0xAAAA_BEEF at addr 0x202 -> `dmem_be=1100`, `dmem_wdata=0xBEEFBEEF`, `dmem_we=1`.
- LW at addr 0x101 -> no `dmem_req`, `misalign_out` pulses 1 cycle, `wb_valid=0`, `wb_RegWrite=0`, no stall.
- LW with `dmem_ready` held low, `WAIT_TIMEOUT=4` -> `stall_out` high 5 cycles, `bus_error_out` pulse, `dmem_req` low after; with ready arriving on cycle 3, the access completes normally instead.
- `rst` asserted mid-ACCESS -> `dmem_req`, `stall_out` and all `wb_*` go to 0 immediately. After release, the next LW completes normally.
